branch_predictor: RTL and testbench

//  Dynamic branch predictor for the fetch stage; successor to the combinational branch resolve logic.

---
 rtl/branch_pkg.sv | 43 ++++
 rtl/branch_predictor_ras.sv | 43 ++++
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and counter helpers for the dynamic branch predictor.
// BTB geometry is fixed here so the entry struct can be shared between modules.
package branch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned BTB_ENTRIES = 16;
  localparam int unsigned IDX_W       = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W       = XLEN - IDX_W - 2;
  localparam int unsigned CNT_MAX_W   = 4;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JUMP   = 2'd1,
    CALL   = 2'd2,
    RET    = 2'd3
  } kind_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    kind_e            kind;
    logic [XLEN-1:0]  target;
  } btb_entry_t;

  // Counters are carried at CNT_MAX_W bits; 'bits' is the live counter width.
  function automatic logic [CNT_MAX_W-1:0] sat_inc(input logic [CNT_MAX_W-1:0] c,
                                                   input int unsigned bits);
    logic [CNT_MAX_W-1:0] max_v;
    max_v = CNT_MAX_W'((1 << bits) - 1);
    return (c >= max_v) ? max_v : c + 1'b1;
  endfunction

  function automatic logic [CNT_MAX_W-1:0] sat_dec(input logic [CNT_MAX_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  // Weakly-taken / weakly-not-taken values straddle the MSB boundary.
  function automatic logic [CNT_MAX_W-1:0] cnt_reset(input int unsigned bits,
                                                     input logic weak_taken);
    return weak_taken ? CNT_MAX_W'(1 << (bits - 1)) : CNT_MAX_W'((1 << (bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// Circular return-address stack; pushing when full overwrites the oldest entry.
module return_address_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] count_q;

  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = stack_q[top_idx];
  assign empty_o = (count_q == '0);

  // ptr_q is the next free slot; it wraps so a full push lands on the oldest entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) stack_q[i] <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else if (push_i) begin
      stack_q[ptr_q] <= data_i;
      ptr_q          <= ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_q   <= top_idx;
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB with direction counters and a RAS,
// trained by resolved outcomes from execute.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned PERF_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN-1:0]   fetch_pc_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              res_valid_i,
  input  logic [XLEN-1:0]   res_pc_i,
  input  logic [1:0]        res_kind_i,
  input  logic              res_taken_i,
  input  logic [XLEN-1:0]   res_target_i,
  input  logic              res_pred_taken_i,
  input  logic [XLEN-1:0]   res_pred_target_i,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic [PERF_W-1:0] mispredict_cnt_o
);

  btb_entry_t          btb_q [BTB_ENTRIES];
  logic [CNT_BITS-1:0] cnt_q [BTB_ENTRIES];
  logic [PERF_W-1:0]   mis_cnt_q;

  logic [IDX_W-1:0]    f_idx, r_idx;
  logic [TAG_W-1:0]    f_tag, r_tag;
  btb_entry_t          f_ent, r_ent;
  logic                f_hit, r_hit;
  kind_e               r_kind;
  logic [CNT_BITS-1:0] cnt_d;
  logic [XLEN-1:0]     ras_top;
  logic                ras_empty;

  assign f_idx  = fetch_pc_i[IDX_W+1:2];
  assign f_tag  = fetch_pc_i[XLEN-1:IDX_W+2];
  assign f_ent  = btb_q[f_idx];
  assign f_hit  = f_ent.valid && (f_ent.tag == f_tag);

  assign r_idx  = res_pc_i[IDX_W+1:2];
  assign r_tag  = res_pc_i[XLEN-1:IDX_W+2];
  assign r_ent  = btb_q[r_idx];
  assign r_hit  = r_ent.valid && (r_ent.tag == r_tag);
  assign r_kind = kind_e'(res_kind_i);

  assign mispredict_cnt_o = mis_cnt_q;

  // Same-cycle lookup; tables are read before any update of this edge lands.
  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = fetch_pc_i + XLEN'(4);
    if (f_hit) begin
      case (f_ent.kind)
        RET: begin
          pred_taken_o  = 1'b1;
          pred_target_o = ras_empty ? f_ent.target : ras_top;
        end
        JUMP, CALL: begin
          pred_taken_o  = 1'b1;
          pred_target_o = f_ent.target;
        end
        default: begin
          if (cnt_q[f_idx][CNT_BITS-1]) begin
            pred_taken_o  = 1'b1;
            pred_target_o = f_ent.target;
          end
        end
      endcase
    end
  end

  always_comb begin
    redirect_o    = res_valid_i &&
                    ((res_taken_i != res_pred_taken_i) ||
                     (res_taken_i && (res_target_i != res_pred_target_i)));
    redirect_pc_o = res_taken_i ? res_target_i : res_pc_i + XLEN'(4);
  end

  // A taken branch landing on a foreign or empty entry starts fresh at weakly-taken.
  always_comb begin
    cnt_d = cnt_q[r_idx];
    if (res_taken_i) begin
      cnt_d = r_hit ? CNT_BITS'(sat_inc(CNT_MAX_W'(cnt_q[r_idx]), CNT_BITS))
                    : CNT_BITS'(cnt_reset(CNT_BITS, 1'b1));
    end else begin
      cnt_d = CNT_BITS'(sat_dec(CNT_MAX_W'(cnt_q[r_idx])));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        btb_q[i] <= '0;
        cnt_q[i] <= CNT_BITS'(cnt_reset(CNT_BITS, 1'b0));
      end
      mis_cnt_q <= '0;
    end else begin
      if (redirect_o && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + PERF_W'(1);
      if (res_valid_i) begin
        if (r_kind == BRANCH) cnt_q[r_idx] <= cnt_d;
        if (res_taken_i) begin
          btb_q[r_idx] <= '{valid: 1'b1, tag: r_tag, kind: r_kind, target: res_target_i};
        end
      end
    end
  end

  return_address_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (XLEN)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (res_valid_i && (r_kind == CALL)),
    .pop_i   (res_valid_i && (r_kind == RET)),
    .data_i  (res_pc_i + XLEN'(4)),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic
// checked against an array/queue reference model.
module tb_branch_predictor;
  import branch_pkg::*;

  localparam int unsigned N         = BTB_ENTRIES;
  localparam int unsigned CNT_BITS  = 2;
  localparam int unsigned RAS_DEPTH = 4;
  localparam int unsigned PERF_W    = 4;
  localparam int          K_BRANCH = 0, K_JUMP = 1, K_CALL = 2, K_RET = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [31:0]       fetch_pc_i = 32'h100;
  logic              pred_taken_o;
  logic [31:0]       pred_target_o;
  logic              res_valid_i = 1'b0;
  logic [31:0]       res_pc_i = '0;
  logic [1:0]        res_kind_i = '0;
  logic              res_taken_i = 1'b0;
  logic [31:0]       res_target_i = '0;
  logic              res_pred_taken_i = 1'b0;
  logic [31:0]       res_pred_target_i = '0;
  logic              redirect_o;
  logic [31:0]       redirect_pc_o;
  logic [PERF_W-1:0] mispredict_cnt_o;

  branch_predictor #(
    .CNT_BITS (CNT_BITS),
    .RAS_DEPTH(RAS_DEPTH),
    .PERF_W   (PERF_W)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .fetch_pc_i       (fetch_pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_kind_i       (res_kind_i),
    .res_taken_i      (res_taken_i),
    .res_target_i     (res_target_i),
    .res_pred_taken_i (res_pred_taken_i),
    .res_pred_target_i(res_pred_target_i),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: plain arrays, a queue for the return stack.
  bit          mv  [N];
  logic [31:0] mtag[N];
  int          mk  [N];
  logic [31:0] mt  [N];
  int          mc  [N];
  logic [31:0] mras[$];
  int          mcnt;

  localparam int CMAX  = (1 << CNT_BITS) - 1;
  localparam int CHALF = 1 << (CNT_BITS - 1);
  localparam int PMAX  = (1 << PERF_W) - 1;

  function automatic void m_reset();
    for (int i = 0; i < int'(N); i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mk[i] = 0; mt[i] = '0; mc[i] = CHALF - 1;
    end
    mras.delete();
    mcnt = 0;
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return mv[m_idx(pc)] && (mtag[m_idx(pc)] == pc / (4 * N));
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit tk, output logic [31:0] tgt);
    int i;
    i   = m_idx(pc);
    tk  = 1'b0;
    tgt = pc + 4;
    if (m_hit(pc)) begin
      if (mk[i] == K_RET) begin
        tk  = 1'b1;
        tgt = (mras.size() > 0) ? mras[$] : mt[i];
      end else if (mk[i] == K_JUMP || mk[i] == K_CALL || mc[i] >= CHALF) begin
        tk  = 1'b1;
        tgt = mt[i];
      end
    end
  endfunction

  function automatic void m_update(input int k, input bit tk, input logic [31:0] tgt,
                                   input logic [31:0] pc);
    int i;
    bit hit;
    i   = m_idx(pc);
    hit = m_hit(pc);
    if (k == K_BRANCH) begin
      if (tk) mc[i] = hit ? ((mc[i] < CMAX) ? mc[i] + 1 : CMAX) : CHALF;
      else    mc[i] = (mc[i] > 0) ? mc[i] - 1 : 0;
    end
    if (tk) begin
      mv[i] = 1'b1; mtag[i] = pc / (4 * N); mk[i] = k; mt[i] = tgt;
    end
    if (k == K_CALL) begin
      mras.push_back(pc + 4);
      if (mras.size() > RAS_DEPTH) void'(mras.pop_front());
    end
    if (k == K_RET && mras.size() > 0) void'(mras.pop_back());
  endfunction

  typedef struct {
    bit          ptk;
    logic [31:0] ptgt;
    bit          rd;
    logic [31:0] rpc;
    bit          chk_rpc;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs settle by the falling edge after each drive.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pred_taken",  {31'b0, pred_taken_o}, {31'b0, e.ptk});
        check("pred_target", pred_target_o, e.ptgt);
        check("redirect",    {31'b0, redirect_o}, {31'b0, e.rd});
        if (e.chk_rpc) check("redirect_pc", redirect_pc_o, e.rpc);
        check("mispredict_cnt", 32'(mispredict_cnt_o), e.cnt);
      end
    end
  end

  task automatic drive(input logic [31:0] fpc, input bit v, input int k, input bit tk,
                       input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                       input logic [31:0] rpc);
    exp_t e;
    @(posedge clk_i);
    #1;
    fetch_pc_i  = fpc;
    res_valid_i = v;
    if (v) begin
      res_pc_i = rpc; res_kind_i = 2'(k); res_taken_i = tk; res_target_i = tgt;
      res_pred_taken_i = ptk; res_pred_target_i = ptgt;
    end else begin
      res_pc_i = 'x; res_kind_i = 'x; res_taken_i = 'x; res_target_i = 'x;
      res_pred_taken_i = 'x; res_pred_target_i = 'x;
    end
    m_predict(fpc, e.ptk, e.ptgt);
    e.rd      = v && ((tk != ptk) || (tk && tgt != ptgt));
    e.rpc     = tk ? tgt : rpc + 4;
    e.chk_rpc = v;
    e.cnt     = 32'(mcnt);
    sb_q.push_back(e);
    if (e.rd && mcnt < PMAX) mcnt++;
    if (v) m_update(k, tk, tgt, rpc);
  endtask

  task automatic idle(input logic [31:0] fpc);
    drive(fpc, 1'b0, 0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Reset lands while a taken update is presented; that update must vanish.
  task automatic mid_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    res_valid_i = 1'b1; res_pc_i = 32'h40; res_kind_i = 2'(K_JUMP); res_taken_i = 1'b1;
    res_target_i = 32'h999c; res_pred_taken_i = 1'b0; res_pred_target_i = '0;
    @(posedge clk_i);
    #2;
    res_valid_i = 1'b0;
    rst_ni = 1'b1;
    m_reset();
  endtask

  initial begin
    bit          ptk, tk, v;
    logic [31:0] ptgt, pc, tgt;
    int          k;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    idle(32'h100);
    // Branch training, then saturation down to strongly not-taken.
    drive(32'h100, 1, K_BRANCH, 1, 32'h180, 0, 32'h204, 32'h200);
    idle(32'h200);
    repeat (3) drive(32'h200, 1, K_BRANCH, 0, 32'h180, 1, 32'h180, 32'h200);
    idle(32'h200);
    // Call/return: RAS top preferred, BTB target once the stack drains.
    drive(32'h0, 1, K_CALL, 1, 32'h800, 0, 32'h0, 32'h300);
    drive(32'h0, 1, K_RET, 1, 32'h304, 0, 32'h0, 32'h810);
    drive(32'h810, 1, K_CALL, 1, 32'h800, 0, 32'h0, 32'h500);
    drive(32'h810, 1, K_RET, 1, 32'h504, 1, 32'h504, 32'h810);
    idle(32'h810);
    // Overfill the stack, drain it, then pop once more on empty.
    for (int c = 0; c <= int'(RAS_DEPTH); c++)
      drive(32'h810, 1, K_CALL, 1, 32'h2000, 0, 32'h0, 32'h1000 + 32'(16 * c));
    for (int p = 0; p <= int'(RAS_DEPTH); p++)
      drive(32'h810, 1, K_RET, 1, 32'h304, 1, 32'h304, 32'h810);
    idle(32'h810);
    // Two PCs sharing one index.
    drive(32'h0, 1, K_JUMP, 1, 32'h400, 0, 32'h0, 32'h40);
    drive(32'h40, 1, K_JUMP, 1, 32'h500, 0, 32'h0, 32'h40 + 32'(4 * N));
    idle(32'h40);
    idle(32'h40 + 32'(4 * N));
    mid_reset();
    idle(32'h40 + 32'(4 * N));
    idle(32'h40);

    for (int n = 0; n < 600; n++) begin
      if (n == 200 || n == 400) mid_reset();
      v   = ($urandom_range(0, 3) != 0);
      pc  = 32'h1000 + 32'(4 * $urandom_range(0, 2 * N - 1));
      k   = int'($urandom_range(0, 3));
      tk  = (k == K_BRANCH) ? 1'($urandom_range(0, 1)) : 1'b1;
      tgt = 32'h3000 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        m_predict(pc, ptk, ptgt);
      end else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = 32'h3000 + 32'(4 * $urandom_range(0, 7));
      end
      drive(32'h1000 + 32'(4 * $urandom_range(0, 2 * N - 1)), v, k, tk, tgt, ptk, ptgt, pc);
    end

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk_i);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never checked", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
